serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing a − b − bin one bit per clock, LSB first. A single full-subtractor cell is time-shared with a borrow flip-flop. The block is the area-lean counterpart to the parallel adder datapath. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_fs.sv | 14 +
 rtl/serial_subtractor.sv | 151 +++++++++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state type and encoding width
// for the bit-serial subtractor.
package serial_subtractor_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: one-bit combinational subtractor cell, x - y - bi.
// Ports: x, y, bi in; d difference bit, bo borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock,
// valid/ready on both sides. Ports: clk, rst (sync, active high),
// in_valid/in_ready/a/b/bin, out_valid/out_ready/diff/bout, busy.
// Optional ovf (signed overflow) output with SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cell_d, cell_bo;
   logic [WIDTH-1:0] diff_sr_nxt;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;
`endif

   full_subtractor u_fs (
      .x  (a_sr_q[0]),
      .y  (b_sr_q[0]),
      .bi (borrow_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   // New bit enters at the MSB so the LSB-first stream lands in place.
   assign diff_sr_nxt = (diff_sr_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

   always_comb begin
      state_d   = state_q;
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      diff_sr_d = diff_sr_q;
      diff_d    = diff_q;
      borrow_d  = borrow_q;
      bout_d    = bout_q;
      cnt_d     = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_d   = a_msb_q;
      b_msb_d   = b_msb_q;
      ovf_d     = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d   = a;
               b_sr_d   = b;
               borrow_d = bin;
               cnt_d    = '0;
               state_d  = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
`endif
            end
         end
         SHIFT: begin
            a_sr_d    = a_sr_q >> 1;
            b_sr_d    = b_sr_q >> 1;
            diff_sr_d = diff_sr_nxt;
            borrow_d  = cell_bo;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               diff_d  = diff_sr_nxt;
               bout_d  = cell_bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               // cell_d is the final MSB of the difference here.
               ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         diff_sr_q <= '0;
         diff_q    <= '0;
         borrow_q  <= 1'b0;
         bout_q    <= 1'b0;
         cnt_q     <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb_q   <= 1'b0;
         b_msb_q   <= 1'b0;
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         diff_sr_q <= diff_sr_d;
         diff_q    <= diff_d;
         borrow_q  <= borrow_d;
         bout_q    <= bout_d;
         cnt_q     <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb_q   <= a_msb_d;
         b_msb_q   <= b_msb_d;
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign diff      = diff_q;
   assign bout      = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for serial_subtractor, WIDTH=8.
// Covers ovf vectors when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .busy      (busy)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits up to 20 edges for out_valid; returns edges waited (0 on timeout).
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
         if (in_ready) chk("in_ready_low_busy", 32'(in_ready), 0);
      end
      if (lat == 0) chk("timeout_out_valid", 0, 1);
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] ai,
                        input logic [W-1:0] bi_, input logic bi_in,
                        input logic [W-1:0] ed, input logic eb);
      int lat;
      chk({tag, "_in_ready"}, 32'(in_ready), 1);
      a = ai; b = bi_; bin = bi_in; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 1);
      wait_done(lat);
      chk({tag, "_latency"}, 32'(lat), W);
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_bout"}, 32'(bout), 32'(eb));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int acc_t[$];
      int nres;
      logic acc;
      logic [W-1:0] sa;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_diff", 32'(diff), 0);
      chk("rst_bout", 32'(bout), 0);
      chk("rst_busy", 32'(busy), 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("rst_ovf", 32'(ovf), 0);
`endif
      // out_ready outside DONE has no effect
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("idle_out_ready_noeffect", 32'(out_valid), 0);

      do_op("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
      release_out();
      chk("basic_back_idle", 32'(in_ready), 1);
      do_op("wrap0", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      release_out();
      do_op("wrap1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
      release_out();

      // Backpressure with a pending second request
      do_op("bp1", 8'h20, 8'h03, 1'b0, 8'h1D, 1'b0);
      a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_valid", 32'(out_valid), 1);
         chk("bp_hold_diff", 32'(diff), 32'h1D);
         chk("bp_hold_bout", 32'(bout), 0);
         chk("bp_no_accept", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_idle_ready", 32'(in_ready), 1);
      chk("bp_idle_valid", 32'(out_valid), 0);
      chk("bp_idle_diff_kept", 32'(diff), 32'h1D);
      tick();
      in_valid = 1'b0;
      chk("bp2_accepted", 32'(busy), 1);
      wait_done(lat);
      chk("bp2_latency", 32'(lat), W);
      chk("bp2_diff", 32'(diff), 32'h55);
      chk("bp2_bout", 32'(bout), 0);
      release_out();

      // Reset sampled on the 3rd shift edge
      a = 8'h33; b = 8'h11; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_diff", 32'(diff), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      do_op("after_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);
      release_out();

      // Streaming with out_ready tied high
      out_ready = 1'b1;
      sa = 8'h30; a = sa; b = 8'h10; bin = 1'b0; in_valid = 1'b1;
      nres = 0;
      for (int i = 0; i < 36; i++) begin
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            acc_t.push_back(cyc);
            sa = sa + 8'h01;
            a = sa;
         end
         if (out_valid) begin
            chk("stream_diff", 32'(diff), 32'(8'h20 + 8'(nres)));
            nres++;
         end
      end
      in_valid = 1'b0;
      chk("stream_accepts", 32'(acc_t.size() >= 3), 1);
      chk("stream_results", 32'(nres >= 3), 1);
      if (acc_t.size() >= 3) begin
         chk("stream_ii_0", 32'(acc_t[1] - acc_t[0]), W + 2);
         chk("stream_ii_1", 32'(acc_t[2] - acc_t[1]), W + 2);
      end
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      out_ready = 1'b0;
      chk("stream_drained", 32'(in_ready), 1);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
      do_op("ovf0", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
      chk("ovf0_ovf", 32'(ovf), 1);
      release_out();
      do_op("ovf1", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
      chk("ovf1_ovf", 32'(ovf), 1);
      release_out();
      do_op("ovf2", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
      chk("ovf2_ovf", 32'(ovf), 0);
      release_out();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
